rv32i_lsu: RTL and testbench

- Load/store unit sitting directly downstream of the RV32I core's memory-access path.
- Accepts one LOAD/STORE request at a time from the core and converts it to a word-aligned, byte-enabled transaction on a valid/ready memory bus.
- Returns a registered writeback response to the core: load data extracted and sign/zero-extended, or a store completion or error.
- Stalls the core through req_ready while a request is outstanding.

---
 rtl/rv32i_lsu.sv | 188 ++++++++++++++++++
 tb/tb_rv32i_lsu.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_lsu.sv
// RV32I load/store unit: turns one core LOAD/STORE into a word-aligned, byte-enabled
// valid/ready bus transaction and returns a registered writeback response. Optional: LSU_TIMEOUT_EN.
module rv32i_lsu #(
    parameter int width   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             CLK,
    input  logic             reset_,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [2:0]       req_funct3,
    input  logic [width-1:0] req_addr,
    input  logic [width-1:0] req_wdata,
    input  logic [4:0]       req_rd,
    output logic             rsp_valid,
    output logic             rsp_we,
    output logic [4:0]       rsp_rd,
    output logic [width-1:0] rsp_data,
    output logic             rsp_err,
    output logic             mem_valid,
    input  logic             mem_ready,
    output logic             mem_we,
    output logic [3:0]       mem_be,
    output logic [width-1:0] mem_addr,
    output logic [width-1:0] mem_wdata,
    input  logic             mem_rvalid,
    input  logic [width-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t             state, next_state;
    logic               we_q;
    logic [2:0]         funct3_q;
    logic [width-1:0]   addr_q;
    logic [width-1:0]   wdata_q;
    logic [4:0]         rd_q;
    logic               err_q;
    logic [width-1:0]   data_q;
    logic               req_illegal;
    logic               req_misaligned;
    logic               tmo_hit;
    logic [7:0]         ld_byte;
    logic [15:0]        ld_half;
    logic [width-1:0]   ld_ext;

    // Rejected requests never reach the bus; they go straight to an error response.
    always_comb begin
        req_illegal    = req_we ? (req_funct3[2] || req_funct3[1:0] == 2'b11)
                                : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);
        req_misaligned = 1'b0;
        case (req_funct3[1:0])
            2'b01:   req_misaligned = req_addr[0];
            2'b10:   req_misaligned = (req_addr[1:0] != 2'b00);
            default: req_misaligned = 1'b0;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_cnt;

    always_ff @(posedge CLK or negedge reset_) begin
        if (!reset_)
            tmo_cnt <= '0;
        else if (state == IDLE)
            tmo_cnt <= '0;
        else if (state == REQ || state == WAIT)
            tmo_cnt <= tmo_cnt + 1'b1;
    end

    assign tmo_hit = (state == REQ || state == WAIT) && (tmo_cnt == TMO_W'(TIMEOUT - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        ld_byte = mem_rdata[7:0];
        case (addr_q[1:0])
            2'b01:   ld_byte = mem_rdata[15:8];
            2'b10:   ld_byte = mem_rdata[23:16];
            2'b11:   ld_byte = mem_rdata[31:24];
            default: ld_byte = mem_rdata[7:0];
        endcase
        ld_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'h0, ld_byte};
            3'b101:  ld_ext = {16'h0, ld_half};
            default: ld_ext = mem_rdata;
        endcase
    end

    always_ff @(posedge CLK or negedge reset_) begin
        if (!reset_)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (req_valid) next_state = (req_illegal || req_misaligned) ? DONE : REQ;
            REQ: begin
                if (mem_ready)    next_state = we_q ? DONE : WAIT;
                else if (tmo_hit) next_state = DONE;
            end
            WAIT: if (mem_rvalid || tmo_hit) next_state = DONE;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Request fields are captured once at acceptance; load data once in WAIT.
    always_ff @(posedge CLK or negedge reset_) begin
        if (!reset_) begin
            we_q     <= 1'b0;
            funct3_q <= 3'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rd_q     <= 5'b0;
            err_q    <= 1'b0;
            data_q   <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    we_q     <= req_we;
                    funct3_q <= req_funct3;
                    addr_q   <= req_addr;
                    wdata_q  <= req_wdata;
                    rd_q     <= req_rd;
                    err_q    <= req_illegal || req_misaligned;
                    data_q   <= '0;
                end
                REQ:  if (!mem_ready && tmo_hit) err_q <= 1'b1;
                WAIT: begin
                    if (mem_rvalid)   data_q <= ld_ext;
                    else if (tmo_hit) err_q  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        req_ready = (state == IDLE);
        mem_valid = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        rsp_valid = 1'b0;
        rsp_we    = 1'b0;
        rsp_rd    = 5'b0;
        rsp_data  = '0;
        rsp_err   = 1'b0;
        if (state == REQ) begin
            mem_valid = 1'b1;
            mem_we    = we_q;
            mem_addr  = {addr_q[width-1:2], 2'b00};
            case (funct3_q[1:0])
                2'b00: begin
                    mem_be    = 4'b0001 << addr_q[1:0];
                    mem_wdata = {4{wdata_q[7:0]}};
                end
                2'b01: begin
                    mem_be    = 4'b0011 << {addr_q[1], 1'b0};
                    mem_wdata = {2{wdata_q[15:0]}};
                end
                default: begin
                    mem_be    = 4'b1111;
                    mem_wdata = wdata_q;
                end
            endcase
        end
        if (state == DONE) begin
            rsp_valid = 1'b1;
            rsp_rd    = rd_q;
            rsp_err   = err_q;
            rsp_we    = !err_q && !we_q && (rd_q != 5'd0);
            rsp_data  = (!err_q && !we_q) ? data_q : '0;
        end
    end

endmodule

// File: tb/tb_rv32i_lsu.sv
// Directed self-checking bench for rv32i_lsu: stores, loads, errors, stalls and mid-operation reset.
module tb_rv32i_lsu;

    logic        CLK;
    logic        reset_;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        rsp_valid;
    logic        rsp_we;
    logic [4:0]  rsp_rd;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int tests_run;
    int tests_failed;

    rv32i_lsu dut (
        .CLK(CLK), .reset_(reset_),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .rsp_valid(rsp_valid), .rsp_we(rsp_we), .rsp_rd(rsp_rd), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Presents one request for a single accepting edge, then withdraws it.
    task automatic apply_stimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [4:0] rd);
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        req_rd     = rd;
        req_valid  = 1'b1;
        step();
        req_valid  = 1'b0;
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        reset_ = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
        req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        #1;
        check_output("rst_req_ready", req_ready, 1);
        check_output("rst_mem_valid", mem_valid, 0);
        check_output("rst_mem_be", mem_be, 0);
        check_output("rst_rsp_valid", rsp_valid, 0);
        check_output("rst_rsp_data", rsp_data, 0);
        step();
        step();
        reset_ = 1'b1;

        // SW to 0x100 with the bus already ready
        mem_ready = 1'b1;
        apply_stimulus(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd3);
        check_output("sw_mem_valid", mem_valid, 1);
        check_output("sw_mem_we", mem_we, 1);
        check_output("sw_mem_be", mem_be, 32'hF);
        check_output("sw_mem_addr", mem_addr, 32'h100);
        check_output("sw_mem_wdata", mem_wdata, 32'hDEADBEEF);
        check_output("sw_req_ready", req_ready, 0);
        check_output("sw_rsp_early", rsp_valid, 0);
        step();
        check_output("sw_rsp_valid", rsp_valid, 1);
        check_output("sw_rsp_we", rsp_we, 0);
        check_output("sw_rsp_err", rsp_err, 0);
        check_output("sw_rsp_data", rsp_data, 0);
        check_output("sw_mem_drop", mem_valid, 0);
        step();
        check_output("sw_rsp_pulse", rsp_valid, 0);
        check_output("sw_idle_ready", req_ready, 1);

        // LB / LBU at 0x103, read data returned at the first opportunity
        mem_rdata = 32'h80FF1234;
        mem_rvalid = 1'b1;
        apply_stimulus(1'b0, 3'b000, 32'h103, 32'h0, 5'd5);
        check_output("lb_mem_be", mem_be, 32'h8);
        check_output("lb_mem_addr", mem_addr, 32'h100);
        check_output("lb_mem_we", mem_we, 0);
        step();
        check_output("lb_wait_novalid", rsp_valid, 0);
        step();
        check_output("lb_rsp_valid", rsp_valid, 1);
        check_output("lb_rsp_data", rsp_data, 32'hFFFFFF80);
        check_output("lb_rsp_we", rsp_we, 1);
        check_output("lb_rsp_rd", rsp_rd, 5);
        step();
        apply_stimulus(1'b0, 3'b100, 32'h103, 32'h0, 5'd0);
        step();
        step();
        check_output("lbu_rsp_valid", rsp_valid, 1);
        check_output("lbu_rsp_data", rsp_data, 32'h00000080);
        check_output("lbu_rsp_we_x0", rsp_we, 0);
        step();

        // Half and word loads from the same word
        apply_stimulus(1'b0, 3'b001, 32'h102, 32'h0, 5'd6);
        check_output("lh_mem_be", mem_be, 32'hC);
        step();
        step();
        check_output("lh_rsp_data", rsp_data, 32'hFFFF80FF);
        step();
        apply_stimulus(1'b0, 3'b101, 32'h100, 32'h0, 5'd6);
        step();
        step();
        check_output("lhu_rsp_data", rsp_data, 32'h00001234);
        step();
        apply_stimulus(1'b0, 3'b010, 32'h100, 32'h0, 5'd9);
        step();
        step();
        check_output("lw_rsp_data", rsp_data, 32'h80FF1234);
        check_output("lw_rsp_rd", rsp_rd, 9);
        step();
        mem_rvalid = 1'b0;

        // SH to 0x202 and SB to 0x301
        apply_stimulus(1'b1, 3'b001, 32'h202, 32'h0000ABCD, 5'd0);
        check_output("sh_mem_addr", mem_addr, 32'h200);
        check_output("sh_mem_be", mem_be, 32'hC);
        check_output("sh_mem_wdata", mem_wdata, 32'hABCDABCD);
        step();
        step();
        apply_stimulus(1'b1, 3'b000, 32'h301, 32'h123456A5, 5'd0);
        check_output("sb_mem_be", mem_be, 32'h2);
        check_output("sb_mem_wdata", mem_wdata, 32'hA5A5A5A5);
        step();
        step();

        // Misaligned and illegal requests answer next cycle with no bus activity
        apply_stimulus(1'b0, 3'b010, 32'h101, 32'h0, 5'd4);
        check_output("mis_mem_valid", mem_valid, 0);
        check_output("mis_rsp_valid", rsp_valid, 1);
        check_output("mis_rsp_err", rsp_err, 1);
        check_output("mis_rsp_data", rsp_data, 0);
        check_output("mis_rsp_we", rsp_we, 0);
        step();
        apply_stimulus(1'b0, 3'b011, 32'h100, 32'h0, 5'd4);
        check_output("ill_mem_valid", mem_valid, 0);
        check_output("ill_rsp_err", rsp_err, 1);
        step();
        apply_stimulus(1'b1, 3'b100, 32'h100, 32'h0, 5'd0);
        check_output("ill_st_rsp_err", rsp_err, 1);
        check_output("ill_st_mem_valid", mem_valid, 0);
        step();
        apply_stimulus(1'b1, 3'b001, 32'h201, 32'h0, 5'd0);
        check_output("mis_sh_rsp_err", rsp_err, 1);
        step();

        // Stalled bus with the core holding its request
        mem_ready = 1'b0;
        req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h300; req_rd = 5'd7;
        req_valid = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            check_output("stall_mem_valid", mem_valid, 1);
            check_output("stall_mem_addr", mem_addr, 32'h300);
            check_output("stall_mem_be", mem_be, 32'hF);
            check_output("stall_req_ready", req_ready, 0);
            step();
        end
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        check_output("stall_wait_ready", req_ready, 0);
        mem_rdata = 32'h11223344;
        mem_rvalid = 1'b1;
        step();
        mem_rvalid = 1'b0;
        check_output("stall_rsp_valid", rsp_valid, 1);
        check_output("stall_rsp_data", rsp_data, 32'h11223344);
        check_output("stall_done_ready", req_ready, 0);
        step();
        check_output("stall_idle_ready", req_ready, 1);
        check_output("stall_idle_mem", mem_valid, 0);
        step();
        req_valid = 1'b0;
        check_output("stall_second_acc", mem_valid, 1);
        mem_ready = 1'b1;
        step();
        mem_rvalid = 1'b1;
        step();
        mem_rvalid = 1'b0;
        step();

        // Reset while waiting for read data; a stale rvalid must be ignored
        mem_ready = 1'b1;
        apply_stimulus(1'b0, 3'b010, 32'h400, 32'h0, 5'd8);
        step();
        check_output("rw_in_wait", mem_valid, 0);
        reset_ = 1'b0;
        #1;
        check_output("rw_mem_valid", mem_valid, 0);
        check_output("rw_req_ready", req_ready, 1);
        check_output("rw_rsp_valid", rsp_valid, 0);
        step();
        reset_ = 1'b1;
        mem_ready = 1'b0;
        mem_rvalid = 1'b1;
        step();
        mem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_output("rw_no_rsp", rsp_valid, 0);
            check_output("rw_idle", req_ready, 1);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
